// File: rtl/sram_ctl_pkg.sv
// sram_ctl_pkg: shared types and helpers for the SRAM controller.
// Holds the write-gatherer FSM state enum, the port index width and clog2.
package sram_ctl_pkg;

  // Returns at least 1 so that single-entry configurations still get
  // a legal vector width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int NUM_PORTS_DEF = 16;
  localparam int PORT_IDX_W = clog2(NUM_PORTS_DEF);

  typedef enum logic [2:0] {
    IDLE,
    ALLOC,
    STREAM,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/wr_gather_rr_arb.sv
// wr_gather_rr_arb: rotating-priority arbiter for the write gatherer.
// Ports: clk, rst (sync, active-high), req[N], load -> gnt[N] (one-hot), idx.
// The search starts at ptr; load moves ptr to one past the granted index.
module wr_gather_rr_arb
  import sram_ctl_pkg::*;
#(
  parameter int N = 16,
  parameter int IW = clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          load,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        found = 1'b1;
        gnt[(int'(ptr) + i) % N] = 1'b1;
        idx = IW'((int'(ptr) + i) % N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (load && found) begin
      ptr <= (int'(idx) == N - 1) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/sram_wr_gather.sv
// sram_wr_gather: multi-port packet write gatherer in front of the SRAM.
// Ports: in_* per-port word/header stream with one-hot in_ready;
//   alloc_* request/grant of a base address; sram_* registered write port
//   stalled by sram_busy; pkt_* one-cycle completion report.
// Optional WR_GATHER_PARITY_EN adds sram_wpar, even parity per wdata byte.
module sram_wr_gather
  import sram_ctl_pkg::*;
#(
  parameter int NUM_PORTS  = 16,
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 12,
  parameter int DES_W      = 4,
  parameter int PRI_W      = 3,
  parameter int LEN_W      = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        in_valid,
  input  logic [NUM_PORTS*DATA_W-1:0] in_data,
  input  logic [NUM_PORTS-1:0]        in_eop,
  input  logic [NUM_PORTS*DES_W-1:0]  in_des,
  input  logic [NUM_PORTS*PRI_W-1:0]  in_pri,
  input  logic [NUM_PORTS*LEN_W-1:0]  in_len,
  output logic [NUM_PORTS-1:0]        in_ready,
  output logic                        alloc_req,
  output logic [DES_W-1:0]            alloc_des,
  output logic [PRI_W-1:0]            alloc_pri,
  output logic [LEN_W-1:0]            alloc_len,
  input  logic                        alloc_gnt,
  input  logic [ADDR_W-1:0]           alloc_base,
  output logic                        sram_we,
  output logic [ADDR_W-1:0]           sram_addr,
  output logic [DATA_W-1:0]           sram_wdata,
  input  logic                        sram_busy,
  output logic                        pkt_done,
  output logic [clog2(NUM_PORTS)-1:0] pkt_port,
  output logic [ADDR_W-1:0]           pkt_base,
  output logic                        pkt_err
`ifdef WR_GATHER_PARITY_EN
  ,
  output logic [DATA_W/8-1:0]         sram_wpar
`endif
);

  localparam int PW = clog2(NUM_PORTS);
  localparam int AW = clog2(FIFO_DEPTH);
  localparam int CW = LEN_W + 1;

  state_t            state;
  logic [PW-1:0]     port;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] wr_off;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nx;
  logic              err;

  logic [NUM_PORTS-1:0] arb_gnt;
  logic [PW-1:0]        arb_idx;
  logic                 arb_load;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wp;
  logic [AW:0]       rp;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] cur_data;
  logic              cur_eop;
  logic              acc;
  logic              push;
  logic              pop;

  wr_gather_rr_arb #(
    .N  (NUM_PORTS),
    .IW (PW)
  ) u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (in_valid),
    .load (arb_load),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  assign arb_load = (state == IDLE) && (|arb_gnt);

  // Extra MSB on the pointers separates full from empty.
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign head  = mem[rp[AW-1:0]];

  assign cur_data = in_data[int'(port)*DATA_W +: DATA_W];
  assign cur_eop  = in_eop[port];

  // Ready follows the registered full flag only: a same-cycle pop
  // never lets an extra word in.
  assign acc  = (state == STREAM) && !full && in_valid[port];
  // Words past the header length are taken but not stored.
  assign push = acc && (cnt < {1'b0, len});
  assign pop  = ((state == STREAM) || (state == DRAIN)) &&
                !empty && !sram_busy;

  // Saturate so very long packets still flag a length error.
  assign cnt_nx = (&cnt) ? cnt : cnt + 1'b1;

  always_comb begin
    in_ready = '0;
    if ((state == STREAM) && !full) in_ready[port] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= cur_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      port       <= '0;
      len        <= '0;
      base       <= '0;
      wr_off     <= '0;
      cnt        <= '0;
      err        <= 1'b0;
      wp         <= '0;
      rp         <= '0;
      alloc_req  <= 1'b0;
      alloc_des  <= '0;
      alloc_pri  <= '0;
      alloc_len  <= '0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      pkt_done   <= 1'b0;
      pkt_port   <= '0;
      pkt_base   <= '0;
      pkt_err    <= 1'b0;
    end else begin
      sram_we <= pop;
      if (pop) begin
        sram_addr  <= base + wr_off;
        sram_wdata <= head;
        wr_off     <= wr_off + 1'b1;
        rp         <= rp + 1'b1;
      end
      if (push) wp <= wp + 1'b1;

      unique case (state)
        IDLE: begin
          pkt_done <= 1'b0;
          if (arb_load) begin
            port      <= arb_idx;
            len       <= in_len[int'(arb_idx)*LEN_W +: LEN_W];
            alloc_req <= 1'b1;
            alloc_des <= in_des[int'(arb_idx)*DES_W +: DES_W];
            alloc_pri <= in_pri[int'(arb_idx)*PRI_W +: PRI_W];
            alloc_len <= in_len[int'(arb_idx)*LEN_W +: LEN_W];
            state     <= ALLOC;
          end
        end
        ALLOC: begin
          if (alloc_gnt) begin
            alloc_req <= 1'b0;
            base      <= alloc_base;
            wr_off    <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (acc) begin
            cnt <= cnt_nx;
            if (cur_eop) begin
              err   <= (cnt_nx != {1'b0, len});
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (empty) begin
            pkt_done <= 1'b1;
            pkt_port <= port;
            pkt_base <= base;
            pkt_err  <= err;
            state    <= DONE;
          end
        end
        DONE: begin
          pkt_done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WR_GATHER_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_wpar <= '0;
    end else if (pop) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        sram_wpar[b] <= ^head[8*b +: 8];
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_wr_gather.sv
// tb_sram_wr_gather: directed bench for sram_wr_gather.
// Source, allocator and SRAM models with queue-based expectations.
module tb_sram_wr_gather;

  localparam int NP  = 16;
  localparam int DW  = 64;
  localparam int AW  = 12;
  localparam int DSW = 4;
  localparam int PRW = 3;
  localparam int LW  = 7;
  localparam int PW  = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          eop;
  } src_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct packed {
    logic [PW-1:0] port;
    logic [AW-1:0] base;
    logic          err;
  } done_t;

  typedef struct packed {
    logic [DSW-1:0] des;
    logic [PRW-1:0] pri;
    logic [LW-1:0]  len;
    logic [AW-1:0]  base;
  } al_t;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0]     in_valid;
  logic [NP*DW-1:0]  in_data;
  logic [NP-1:0]     in_eop;
  logic [NP*DSW-1:0] in_des;
  logic [NP*PRW-1:0] in_pri;
  logic [NP*LW-1:0]  in_len;
  logic [NP-1:0]     in_ready;
  logic              alloc_req;
  logic [DSW-1:0]    alloc_des;
  logic [PRW-1:0]    alloc_pri;
  logic [LW-1:0]     alloc_len;
  logic              alloc_gnt;
  logic [AW-1:0]     alloc_base;
  logic              sram_we;
  logic [AW-1:0]     sram_addr;
  logic [DW-1:0]     sram_wdata;
  logic              sram_busy;
  logic              pkt_done;
  logic [PW-1:0]     pkt_port;
  logic [AW-1:0]     pkt_base;
  logic              pkt_err;
`ifdef WR_GATHER_PARITY_EN
  logic [DW/8-1:0]   sram_wpar;
`endif

  src_t  src_q[NP][$];
  wr_t   wq[$];
  done_t dq[$];
  al_t   aq[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit ignore_wr = 1'b0;
  bit busy_prev = 1'b0;
  int fired[NP] = '{default: 0};
  bit pend[NP] = '{default: 1'b0};

  sram_wr_gather dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_eop     (in_eop),
    .in_des     (in_des),
    .in_pri     (in_pri),
    .in_len     (in_len),
    .in_ready   (in_ready),
    .alloc_req  (alloc_req),
    .alloc_des  (alloc_des),
    .alloc_pri  (alloc_pri),
    .alloc_len  (alloc_len),
    .alloc_gnt  (alloc_gnt),
    .alloc_base (alloc_base),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_busy  (sram_busy),
    .pkt_done   (pkt_done),
    .pkt_port   (pkt_port),
    .pkt_base   (pkt_base),
    .pkt_err    (pkt_err)
`ifdef WR_GATHER_PARITY_EN
    ,
    .sram_wpar  (sram_wpar)
`endif
  );

  initial forever #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: run did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

`ifdef WR_GATHER_PARITY_EN
  function automatic logic [DW/8-1:0] par(input logic [DW-1:0] d);
    logic [DW/8-1:0] p;
    for (int b = 0; b < DW / 8; b++) p[b] = ^d[8*b +: 8];
    return p;
  endfunction
`endif

  function automatic int src_left();
    int n;
    n = 0;
    for (int p = 0; p < NP; p++) n += src_q[p].size();
    return n;
  endfunction

  // Source model: one word per port in flight, advanced on handshake.
  initial begin
    src_t s;
    in_valid = '0;
    in_eop   = '0;
    in_data  = '0;
    forever begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
        if (pend[p] && src_q[p].size() != 0) begin
          void'(src_q[p].pop_front());
          fired[p]++;
        end
        if (src_q[p].size() != 0) begin
          s = src_q[p][0];
          in_valid[p] = 1'b1;
          in_data[p*DW +: DW] = s.data;
          in_eop[p] = s.eop;
        end else begin
          in_valid[p] = 1'b0;
          in_eop[p] = 1'b0;
        end
        pend[p] = in_valid[p] && in_ready[p] && !rst;
      end
    end
  end

  // Allocator model: grants two cycles into a request.
  initial begin
    int dly;
    al_t a;
    alloc_gnt  = 1'b0;
    alloc_base = '0;
    dly = 0;
    forever begin
      @(negedge clk);
      if (alloc_gnt) begin
        alloc_gnt = 1'b0;
        dly = 0;
      end else if (alloc_req && !rst) begin
        dly++;
        if (dly == 2) begin
          chk("alloc_pending", aq.size() != 0, 1);
          if (aq.size() != 0) begin
            a = aq.pop_front();
            chk("alloc_des", alloc_des, a.des);
            chk("alloc_pri", alloc_pri, a.pri);
            chk("alloc_len", alloc_len, a.len);
            alloc_base = a.base;
          end
          alloc_gnt = 1'b1;
        end
      end else begin
        dly = 0;
      end
    end
  end

  // SRAM and completion monitor.
  initial begin
    wr_t w;
    done_t d;
    forever begin
      @(negedge clk);
      if (!rst && !ignore_wr && sram_we) begin
        chk("we_busy", busy_prev, 0);
        chk("wr_pending", wq.size() != 0, 1);
        if (wq.size() != 0) begin
          w = wq.pop_front();
          chk("wr_addr", sram_addr, w.addr);
          chk("wr_data", sram_wdata, w.data);
`ifdef WR_GATHER_PARITY_EN
          chk("wr_par", sram_wpar, par(w.data));
`endif
        end
      end
      if (!rst && pkt_done) begin
        chk("done_pending", dq.size() != 0, 1);
        if (dq.size() != 0) begin
          d = dq.pop_front();
          chk("done_port", pkt_port, d.port);
          chk("done_base", pkt_base, d.base);
          chk("done_err", pkt_err, d.err);
        end
      end
      busy_prev = sram_busy;
    end
  end

  task automatic send(input int port, input int hlen, input int nw,
                      input logic [AW-1:0] base,
                      input logic [DW-1:0] d0, input bit exp_on);
    logic [DSW-1:0] des;
    logic [PRW-1:0] pri;
    logic [AW-1:0]  a;
    logic [DW-1:0]  d;
    src_t s;
    al_t  al;
    wr_t  w;
    done_t dn;
    des = DSW'(port ^ 9);
    pri = PRW'(port);
    in_des[port*DSW +: DSW] = des;
    in_pri[port*PRW +: PRW] = pri;
    in_len[port*LW +: LW]   = LW'(hlen);
    al.des = des;
    al.pri = pri;
    al.len = LW'(hlen);
    al.base = base;
    aq.push_back(al);
    for (int i = 0; i < nw; i++) begin
      d = {$urandom, $urandom};
      if (i == 0 && d0 != '0) d = d0;
      s.data = d;
      s.eop  = (i == nw - 1);
      src_q[port].push_back(s);
      if (exp_on && i < hlen) begin
        a = base + AW'(i);
        w.addr = a;
        w.data = d;
        wq.push_back(w);
      end
    end
    if (exp_on) begin
      dn.port = PW'(port);
      dn.base = base;
      dn.err  = (nw != hlen);
      dq.push_back(dn);
    end
  endtask

  task automatic wait_idle(input int budget);
    int c;
    bit busyq;
    c = 0;
    busyq = 1'b1;
    while (busyq && c < budget) begin
      @(posedge clk);
      #2;
      c++;
      busyq = (wq.size() != 0) || (dq.size() != 0) ||
              (aq.size() != 0) || (src_left() != 0);
    end
    chk("drain_timeout", busyq, 0);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_alloc_req"}, alloc_req, 0);
    chk({tag, "_alloc_hdr"}, {alloc_des, alloc_pri, alloc_len}, 0);
    chk({tag, "_sram_we"}, sram_we, 0);
    chk({tag, "_sram_addr"}, sram_addr, 0);
    chk({tag, "_sram_wdata"}, sram_wdata, 0);
    chk({tag, "_pkt_done"}, pkt_done, 0);
    chk({tag, "_pkt_info"}, {pkt_port, pkt_base, pkt_err}, 0);
  endtask

  initial begin
    int c;
    bit saw_low;
    rst = 1'b1;
    sram_busy = 1'b0;
    in_des = '0;
    in_pri = '0;
    in_len = '0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk_zero("reset");

    // single packet
    send(3, 4, 4, 12'h100, '0, 1'b1);
    wait_idle(300);

    // leave the pointer one past port 5
    send(5, 2, 2, 12'h120, '0, 1'b1);
    wait_idle(300);

    // round robin: expected service order 15, 0, 5
    send(15, 3, 3, 12'h200, '0, 1'b1);
    send(0, 3, 3, 12'h210, '0, 1'b1);
    send(5, 3, 3, 12'h220, '0, 1'b1);
    wait_idle(600);

    // backpressure
    send(1, 8, 8, 12'h300, '0, 1'b1);
    c = 0;
    while (!alloc_gnt && c < 50) begin
      @(posedge clk);
      #2;
      c++;
    end
    chk("bp_gnt", alloc_gnt, 1);
    repeat (2) @(posedge clk);
    #2;
    sram_busy = 1'b1;
    saw_low = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #2;
      if (in_valid[1] && !in_ready[1]) saw_low = 1'b1;
    end
    sram_busy = 1'b0;
    chk("bp_stall", saw_low, 1);
    wait_idle(300);

    // address wrap
    send(7, 4, 4, 12'hFFE, '0, 1'b1);
    wait_idle(300);

    // long, short and zero-length packets
    send(9, 3, 5, 12'h400, '0, 1'b1);
    wait_idle(300);
    send(4, 6, 2, 12'h410, '0, 1'b1);
    wait_idle(300);
    send(10, 0, 2, 12'h420, '0, 1'b1);
    wait_idle(300);

    // reset in the middle of a packet
    ignore_wr = 1'b1;
    send(2, 6, 6, 12'h500, '0, 1'b0);
    c = 0;
    while (fired[2] < 2 && c < 100) begin
      @(posedge clk);
      #2;
      c++;
    end
    chk("rst_words", fired[2] >= 2, 1);
    rst = 1'b1;
    src_q[2].delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk_zero("midrst");
    ignore_wr = 1'b0;
    aq.delete();
    repeat (10) @(posedge clk);
    #2;
    send(6, 4, 4, 12'h600, 64'h1, 1'b1);
    wait_idle(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
